// File: rtl/gpu_pll_pkg.sv
// Shared state encoding, default timing constants and sizing helper for the
// GPU PLL lock sequencer.
package gpu_pll_pkg;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  // Largest of three cycle counts, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpu_sync2.sv
// Two-flop synchronizer for bringing asynchronous levels into the local clock domain.
module gpu_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpu_pll_lock_sequencer.sv
// Drives the PLL reset pulse, waits for a stable lock with bounded retries and
// releases the PLL output domain; all outputs come straight from flops.
module gpu_pll_lock_sequencer
  import gpu_pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_dbg
);

  localparam int CNT_W   = $clog2(max3(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES,
                                       PLL_RST_CYCLES)) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  pll_state_t         state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retries, retries_nxt;
  logic               loss_inc;
  logic               locked_s;

  gpu_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // One counter is shared by every timed phase and is cleared on each state change.
  always_comb begin
    next_state  = state;
    cnt_nxt     = cnt;
    retries_nxt = retries;
    loss_inc    = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          next_state = WAIT_LOCK;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          next_state = STABLE;
          cnt_nxt    = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (retries < RETRY_W'(MAX_RETRIES)) begin
            retries_nxt = retries + RETRY_W'(1);
            next_state  = PLL_RESET;
          end else begin
            next_state = FAIL;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          cnt_nxt    = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES)) begin
          next_state  = RUN;
          cnt_nxt     = '0;
          retries_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state = PLL_RESET;
          cnt_nxt    = '0;
          loss_inc   = 1'b1;
        end
      end
      FAIL: begin
        if (retry_req) begin
          next_state  = PLL_RESET;
          cnt_nxt     = '0;
          retries_nxt = '0;
        end
      end
      default: begin
        next_state = PLL_RESET;
        cnt_nxt    = '0;
      end
    endcase
  end

  // Outputs are decoded from next_state so they change on the same edge as the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      retries         <= '0;
      pll_rst         <= 1'b1;
      core_rst        <= 1'b1;
      ready           <= 1'b0;
      fail            <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_nxt;
      retries  <= retries_nxt;
      pll_rst  <= (next_state == PLL_RESET);
      core_rst <= (next_state != RUN);
      ready    <= (next_state == RUN);
      fail     <= (next_state == FAIL);
      if (loss_inc && (lock_loss_count != 8'hFF)) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
    end
  end

  assign state_dbg = state;

endmodule
